// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the multi-LED pattern sequencer.
package led_seq_pkg;

    localparam int MODE_W   = 3;
    // Widest LED bus the init_pattern helper can describe.
    localparam int LED_MAX  = 64;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 3'd0,
        MODE_BLINK  = 3'd1,
        MODE_ALT    = 3'd2,
        MODE_CHASE  = 3'd3,
        MODE_BOUNCE = 3'd4,
        MODE_FILL   = 3'd5
    } mode_t;

    // Raw mode request to pattern mode; unused codes fall back to OFF.
    function automatic mode_t decode_mode(input logic [MODE_W-1:0] code);
        mode_t m;
        case (code)
            3'd1:    m = MODE_BLINK;
            3'd2:    m = MODE_ALT;
            3'd3:    m = MODE_CHASE;
            3'd4:    m = MODE_BOUNCE;
            3'd5:    m = MODE_FILL;
            default: m = MODE_OFF;
        endcase
        return m;
    endfunction

    // Pattern loaded when a mode becomes active; only the low n bits are meaningful.
    function automatic logic [LED_MAX-1:0] init_pattern(input mode_t m, input int unsigned n);
        logic [LED_MAX-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < LED_MAX; i++) begin
            if (i < n) begin
                case (m)
                    MODE_BLINK:  p[i] = 1'b1;
                    MODE_ALT:    p[i] = (i % 2 == 0);
                    MODE_CHASE,
                    MODE_BOUNCE,
                    MODE_FILL:   p[i] = (i == 0);
                    default:     p[i] = 1'b0;
                endcase
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/led_seq_multi_prescaler.sv
// Two-stage tick prescaler: MF_DIV clocks per mid tick, LF_DIV mid ticks per pattern tick.
module tick_prescaler #(
    parameter int MF_DIV = 20,
    parameter int LF_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick_lf
);

    localparam int MF_W = (MF_DIV > 1) ? $clog2(MF_DIV) : 1;
    localparam int LF_W = (LF_DIV > 1) ? $clog2(LF_DIV) : 1;

    if (MF_DIV < 1) begin : g_bad_mf_div
        $fatal(1, "tick_prescaler: MF_DIV must be >= 1");
    end
    if (LF_DIV < 1) begin : g_bad_lf_div
        $fatal(1, "tick_prescaler: LF_DIV must be >= 1");
    end

    logic [MF_W-1:0] mf_cnt;
    logic [LF_W-1:0] lf_cnt;
    logic            mf_last;
    logic            lf_last;

    assign mf_last = (mf_cnt == MF_W'(MF_DIV - 1));
    assign lf_last = (lf_cnt == LF_W'(LF_DIV - 1));
    assign tick_lf = enable & mf_last & lf_last;

    // Counters: clear restarts the period regardless of enable; otherwise advance only while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mf_cnt <= '0;
            lf_cnt <= '0;
        end else if (clear) begin
            mf_cnt <= '0;
            lf_cnt <= '0;
        end else if (enable) begin
            if (mf_last) begin
                mf_cnt <= '0;
                lf_cnt <= lf_last ? '0 : lf_cnt + LF_W'(1);
            end else begin
                mf_cnt <= mf_cnt + MF_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_seq_multi.sv
// N-channel Moore LED pattern sequencer with integrated two-stage tick prescaler.
module led_seq_multi
    import led_seq_pkg::*;
#(
    parameter int N_LEDS = 4,
    parameter int MF_DIV = 20,
    parameter int LF_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode,
    input  logic              enable,
    output logic [N_LEDS-1:0] led,
    output logic              tick_lf,
    output logic              mode_ack
);

    if (N_LEDS < 2) begin : g_bad_n_leds
        $fatal(1, "led_seq_multi: N_LEDS must be >= 2");
    end
    if (N_LEDS > LED_MAX) begin : g_big_n_leds
        $fatal(1, "led_seq_multi: N_LEDS exceeds LED_MAX");
    end

    mode_t             mode_q, mode_d;
    mode_t             mode_dec;
    logic [N_LEDS-1:0] led_q, led_d;
    logic [N_LEDS-1:0] led_init;
    logic [N_LEDS-1:0] led_step;
    logic              dir_up_q, dir_up_d;
    logic              dir_up_step;
    logic              ack_q, ack_d;
    logic              mode_change;
    logic [LED_MAX-1:0] init_full;

    assign mode_dec    = decode_mode(mode);
    assign mode_change = (mode_dec != mode_q);
    assign init_full   = init_pattern(mode_dec, N_LEDS);
    assign led_init    = init_full[N_LEDS-1:0];

    if (N_LEDS < LED_MAX) begin : g_init_hi
        logic unused_init_hi;
        assign unused_init_hi = ^init_full[LED_MAX-1:N_LEDS];
    end

    assign led      = led_q;
    assign mode_ack = ack_q;

    tick_prescaler #(
        .MF_DIV (MF_DIV),
        .LF_DIV (LF_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .clear   (mode_change),
        .tick_lf (tick_lf)
    );

    // Active mode, LED pattern, bounce direction and acknowledge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            led_q    <= '0;
            dir_up_q <= 1'b1;
            ack_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            led_q    <= led_d;
            dir_up_q <= dir_up_d;
            ack_q    <= ack_d;
        end
    end

    // One pattern step in the active mode, computed from the current LED value.
    always_comb begin
        led_step    = led_q;
        dir_up_step = dir_up_q;
        case (mode_q)
            MODE_OFF: begin
                led_step = '0;
            end
            MODE_BLINK, MODE_ALT: begin
                led_step = ~led_q;
            end
            MODE_CHASE: begin
                led_step = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
            end
            MODE_BOUNCE: begin
                // Turn around at either end so the end value is shown once, not twice.
                if (dir_up_q && led_q[N_LEDS-1]) begin
                    led_step    = led_q >> 1;
                    dir_up_step = 1'b0;
                end else if (!dir_up_q && led_q[0]) begin
                    led_step    = led_q << 1;
                    dir_up_step = 1'b1;
                end else if (dir_up_q) begin
                    led_step = led_q << 1;
                end else begin
                    led_step = led_q >> 1;
                end
            end
            MODE_FILL: begin
                led_step = (&led_q) ? '0 : {led_q[N_LEDS-2:0], 1'b1};
            end
            default: begin
                led_step = '0;
            end
        endcase
    end

    // Next state: a mode change reloads and acknowledges, overriding any coincident step.
    always_comb begin
        mode_d   = mode_q;
        led_d    = led_q;
        dir_up_d = dir_up_q;
        ack_d    = 1'b0;
        if (mode_change) begin
            mode_d   = mode_dec;
            led_d    = led_init;
            dir_up_d = 1'b1;
            ack_d    = 1'b1;
        end else if (tick_lf) begin
            led_d    = led_step;
            dir_up_d = dir_up_step;
        end
    end

endmodule

// File: tb/tb_led_seq_multi.sv
// Scoreboard bench for led_seq_multi (N_LEDS=4, MF_DIV=4, LF_DIV=2: 8 clocks per step).
module tb_led_seq_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] mode;
    logic       enable;
    logic [3:0] led;
    logic       tick_lf;
    logic       mode_ack;

    int checks = 0;
    int errors = 0;

    // Expected output event: LED value, ack flag, clocks since previous event (0 = unchecked).
    typedef struct {
        logic [3:0] led;
        logic       ack;
        int         gap;
    } exp_t;

    exp_t sb_q[$];

    led_seq_multi #(
        .N_LEDS (4),
        .MF_DIV (4),
        .LF_DIV (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .enable   (enable),
        .led      (led),
        .tick_lf  (tick_lf),
        .mode_ack (mode_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] l, input logic a, input int g);
        exp_t e;
        e.led = l;
        e.ack = a;
        e.gap = g;
        sb_q.push_back(e);
    endtask

    task automatic push_steps(input logic [3:0] vals[$]);
        foreach (vals[i]) push(vals[i], 1'b0, 8);
    endtask

    // Ends just after the n-th rising edge from now.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: an output event is any LED change or an ack pulse; each one pops the scoreboard.
    int         cyc       = 0;
    int         last_evt  = 0;
    logic [3:0] prev_led  = '0;
    logic       prev_tick = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            prev_led  = led;
            prev_tick = 1'b0;
        end else begin
            if (!enable) check("tick_while_frozen", {31'b0, tick_lf}, 32'd0);
            if (led !== prev_led || mode_ack) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got led=%0h ack=%0b expected no event at %0t",
                             led, mode_ack, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("led", {28'b0, led}, {28'b0, e.led});
                    check("mode_ack", {31'b0, mode_ack}, {31'b0, e.ack});
                    if (e.gap != 0) check("event_gap", cyc - last_evt, e.gap);
                    if (!mode_ack) check("step_needs_tick", {31'b0, prev_tick}, 32'd1);
                end
                last_evt = cyc;
            end
            prev_led  = led;
            prev_tick = tick_lf;
        end
    end

    initial begin
        rst_n  = 1'b1;
        mode   = 3'd0;
        enable = 1'b0;
        #1 rst_n = 1'b0;
        #3;
        check("reset_led", {28'b0, led}, 32'd0);
        check("reset_ack", {31'b0, mode_ack}, 32'd0);
        check("reset_tick", {31'b0, tick_lf}, 32'd0);
        #13 rst_n = 1'b1;
        wait_edges(2);

        // CHASE
        push(4'h1, 1'b1, 0);
        push_steps('{4'h2, 4'h4, 4'h8, 4'h1});
        mode   = 3'd3;
        enable = 1'b1;
        wait_edges(33);

        // BOUNCE
        push(4'h1, 1'b1, 1);
        push_steps('{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2});
        mode = 3'd4;
        wait_edges(57);

        // FILL
        push(4'h1, 1'b1, 1);
        push_steps('{4'h3, 4'h7, 4'hF, 4'h0, 4'h1});
        mode = 3'd5;
        wait_edges(41);

        // BLINK
        push(4'hF, 1'b1, 1);
        push_steps('{4'h0, 4'hF, 4'h0});
        mode = 3'd1;
        wait_edges(25);

        // CHASE up to 0100, then ALT on the very edge where the step tick is due
        push(4'h1, 1'b1, 1);
        push_steps('{4'h2, 4'h4});
        mode = 3'd3;
        wait_edges(24);
        check("tick_at_collision", {31'b0, tick_lf}, 32'd1);
        push(4'h5, 1'b1, 8);
        push(4'hA, 1'b0, 8);
        mode = 3'd2;
        wait_edges(9);

        // CHASE, frozen for 20 clocks starting 3 clocks into the period
        push(4'h1, 1'b1, 1);
        push(4'h2, 1'b0, 28);
        mode = 3'd3;
        wait_edges(4);
        enable = 1'b0;
        wait_edges(20);
        check("frozen_led", {28'b0, led}, 32'd1);
        enable = 1'b1;
        wait_edges(5);
        enable = 1'b0;
        wait_edges(3);

        // Code 6 decodes as OFF: applies while frozen, then holding it causes nothing
        push(4'h0, 1'b1, 4);
        mode = 3'd6;
        wait_edges(10);
        enable = 1'b1;
        wait_edges(10);

        // BOUNCE to 1000, then asynchronous reset between edges
        push(4'h1, 1'b1, 20);
        push_steps('{4'h2, 4'h4, 4'h8});
        mode = 3'd4;
        wait_edges(28);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_led", {28'b0, led}, 32'd0);
        check("async_reset_ack", {31'b0, mode_ack}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        push(4'h1, 1'b1, 0);
        push(4'h2, 1'b0, 8);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_led", {28'b0, led}, 32'd1);
        check("post_reset_ack", {31'b0, mode_ack}, 32'd1);
        wait_edges(12);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
